data_mem_ctrl: RTL and testbench

Load/store controller between the memory stage and a handshaked external data memory port. It aligns and byte-enables stores, and sign- or zero-extends loads. While a transaction is outstanding it holds the pipeline through a stall output to the hazard unit. It sits directly downstream of the memory stage, and its registered read data feeds the write-back result path.

---
 rtl/data_mem_pkg.sv | 32 +++
 rtl/mem_align.sv | 50 +++++
 rtl/data_mem_ctrl.sv | 172 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared constants and types for the data memory load/store controller.
// Holds the func3 encodings, the FSM state type and the byte-lane geometry.
package data_mem_pkg;

  localparam int LANES = 8;
  localparam int BUS_W = LANES * 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Unshifted lane mask for an access size (func3[1:0]).
  function automatic logic [LANES-1:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store byte enables and shifted data, load
// right-shift with sign/zero extension, and the misalignment/illegal flag.
module mem_align
  import data_mem_pkg::*;
(
  input  logic             st_we,
  input  logic [2:0]       st_func3,
  input  logic [2:0]       st_off,
  input  logic [BUS_W-1:0] st_wdata,
  input  logic [2:0]       ld_func3,
  input  logic [2:0]       ld_off,
  input  logic [BUS_W-1:0] ld_rdata,
  output logic [LANES-1:0] st_be,
  output logic [BUS_W-1:0] st_wdata_sh,
  output logic [BUS_W-1:0] ld_rdata_ext,
  output logic             misaligned
);

  logic [BUS_W-1:0] ld_shifted;

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    misaligned = 1'b0;
    case (st_func3[1:0])
      2'b01:   misaligned = st_off[0];
      2'b10:   misaligned = |st_off[1:0];
      2'b11:   misaligned = |st_off;
      default: misaligned = 1'b0;
    endcase
    // 111 is not a valid access, and stores have no unsigned variants.
    if (st_func3 == 3'b111 || (st_we && st_func3[2])) misaligned = 1'b1;

    st_be       = size_mask(st_func3[1:0]) << st_off;
    st_wdata_sh = st_wdata << {st_off, 3'b000};
  end

  always_comb begin
    ld_shifted = ld_rdata >> {ld_off, 3'b000};
    case (ld_func3)
      F3_B:    ld_rdata_ext = {{56{ld_shifted[7]}},  ld_shifted[7:0]};
      F3_H:    ld_rdata_ext = {{48{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_W:    ld_rdata_ext = {{32{ld_shifted[31]}}, ld_shifted[31:0]};
      F3_BU:   ld_rdata_ext = {56'b0, ld_shifted[7:0]};
      F3_HU:   ld_rdata_ext = {48'b0, ld_shifted[15:0]};
      F3_WU:   ld_rdata_ext = {32'b0, ld_shifted[31:0]};
      default: ld_rdata_ext = ld_shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller between the memory stage and a handshaked data port.
// Optional ack timeout is compiled in with `define DATA_MEM_CTRL_TIMEOUT_EN.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_mem_req,
  input  logic                  i_mem_we,
  input  logic [2:0]            i_func3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_misaligned,
  output logic                  o_bus_err,
  output logic                  o_ext_req,
  output logic                  o_ext_we,
  output logic [ADDR_WIDTH-1:0] o_ext_addr,
  output logic [DATA_WIDTH-1:0] o_ext_wdata,
  output logic [7:0]            o_ext_be,
  input  logic                  i_ext_ack,
  input  logic [DATA_WIDTH-1:0] i_ext_rdata
);

  state_e                state_q, state_d;
  logic                  ext_req_q, ext_req_d;
  logic                  ext_we_q, ext_we_d;
  logic [ADDR_WIDTH-1:0] ext_addr_q, ext_addr_d;
  logic [DATA_WIDTH-1:0] ext_wdata_q, ext_wdata_d;
  logic [7:0]            ext_be_q, ext_be_d;
  logic [2:0]            func3_q, func3_d;
  logic [2:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

`ifdef DATA_MEM_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
`endif

  logic [7:0]            be_w;
  logic [DATA_WIDTH-1:0] wdata_sh_w;
  logic [DATA_WIDTH-1:0] rdata_ext_w;
  logic                  misaligned_w;
  logic                  issue;

  // Store side sees the live request; load side sees the latched access.
  mem_align u_align (
    .st_we        (i_mem_we),
    .st_func3     (i_func3),
    .st_off       (i_addr[2:0]),
    .st_wdata     (i_wdata),
    .ld_func3     (func3_q),
    .ld_off       (off_q),
    .ld_rdata     (i_ext_rdata),
    .st_be        (be_w),
    .st_wdata_sh  (wdata_sh_w),
    .ld_rdata_ext (rdata_ext_w),
    .misaligned   (misaligned_w)
  );

  assign issue = i_mem_req && !misaligned_w;

  always_comb begin
    state_d     = state_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    ext_be_d    = ext_be_q;
    func3_d     = func3_q;
    off_d       = off_q;
    rdata_d     = rdata_q;
`ifdef DATA_MEM_CTRL_TIMEOUT_EN
    cnt_d       = cnt_q;
    bus_err_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d     = REQ;
          ext_req_d   = 1'b1;
          ext_we_d    = i_mem_we;
          ext_addr_d  = {i_addr[ADDR_WIDTH-1:3], 3'b000};
          ext_wdata_d = wdata_sh_w;
          ext_be_d    = be_w;
          func3_d     = i_func3;
          off_d       = i_addr[2:0];
`ifdef DATA_MEM_CTRL_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      REQ: begin
        if (i_ext_ack) begin
          state_d   = DONE;
          ext_req_d = 1'b0;
          rdata_d   = ext_we_q ? '0 : rdata_ext_w;
`ifdef DATA_MEM_CTRL_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Last allowed wait cycle without ack: give up and flag the error.
          state_d   = DONE;
          ext_req_d = 1'b0;
          rdata_d   = '0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + 1'b1;
`endif
        end
      end
      // The pipeline advances out of DONE; the lingering request is not reissued.
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_arst) begin
      // NOTE: every register here is control or a small datapath latch, so all
      // of them take a reset value; nothing is left to power-up state.
      state_q     <= IDLE;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      ext_be_q    <= '0;
      func3_q     <= '0;
      off_q       <= '0;
      rdata_q     <= '0;
`ifdef DATA_MEM_CTRL_TIMEOUT_EN
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      ext_be_q    <= ext_be_d;
      func3_q     <= func3_d;
      off_q       <= off_d;
      rdata_q     <= rdata_d;
`ifdef DATA_MEM_CTRL_TIMEOUT_EN
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign o_stall      = (state_q == IDLE && issue) || (state_q == REQ);
  assign o_misaligned = i_mem_req && misaligned_w;
  assign o_rdata      = rdata_q;
  assign o_ext_req    = ext_req_q;
  assign o_ext_we     = ext_we_q;
  assign o_ext_addr   = ext_addr_q;
  assign o_ext_wdata  = ext_wdata_q;
  assign o_ext_be     = ext_be_q;
`ifdef DATA_MEM_CTRL_TIMEOUT_EN
  assign o_bus_err    = bus_err_q;
`else
  assign o_bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: the driver queues expected bus requests
// and completions, and a monitor pops and compares them as the DUT shows them.
module tb_data_mem_ctrl;
  import data_mem_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        mem_req, mem_we;
  logic [2:0]  func3;
  logic [63:0] addr_i, wdata_i;
  logic        o_stall, o_misaligned, o_bus_err;
  logic [63:0] o_rdata;
  logic        o_ext_req, o_ext_we;
  logic [63:0] o_ext_addr, o_ext_wdata;
  logic [7:0]  o_ext_be;
  logic        ext_ack;
  logic [63:0] ext_rdata;

  always #5 clk = ~clk;

  data_mem_ctrl #(
    .ADDR_WIDTH     (64),
    .DATA_WIDTH     (64),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clk        (clk),
    .i_arst       (arst_n),
    .i_mem_req    (mem_req),
    .i_mem_we     (mem_we),
    .i_func3      (func3),
    .i_addr       (addr_i),
    .i_wdata      (wdata_i),
    .o_stall      (o_stall),
    .o_rdata      (o_rdata),
    .o_misaligned (o_misaligned),
    .o_bus_err    (o_bus_err),
    .o_ext_req    (o_ext_req),
    .o_ext_we     (o_ext_we),
    .o_ext_addr   (o_ext_addr),
    .o_ext_wdata  (o_ext_wdata),
    .o_ext_be     (o_ext_be),
    .i_ext_ack    (ext_ack),
    .i_ext_rdata  (ext_rdata)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  be;
    logic        we;
    logic [63:0] wdata;
  } iss_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } done_t;

  iss_t  iss_q[$];
  done_t done_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_txn(input logic [63:0] a, input logic [7:0] be, input logic we,
                            input logic [63:0] wd, input logic [63:0] rd, input logic err);
    iss_t  ie;
    done_t de;
    ie.addr = a; ie.be = be; ie.we = we; ie.wdata = wd;
    de.rdata = rd; de.err = err;
    iss_q.push_back(ie);
    done_q.push_back(de);
  endtask

  // Monitor: a rising o_ext_req is an issued request, a falling one outside
  // reset is a completion whose result is visible in the DONE cycle.
  initial begin
    logic  prev_req;
    iss_t  ie;
    done_t de;
    prev_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (arst_n) begin
        if (o_ext_req && !prev_req) begin
          if (iss_q.size() == 0) check("unexpected_req", 64'd1, 64'd0);
          else begin
            ie = iss_q.pop_front();
            check("ext_addr",  o_ext_addr,  ie.addr);
            check("ext_be",    {56'b0, o_ext_be}, {56'b0, ie.be});
            check("ext_we",    {63'b0, o_ext_we}, {63'b0, ie.we});
            check("ext_wdata", o_ext_wdata, ie.wdata);
          end
        end
        if (!o_ext_req && prev_req) begin
          if (done_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
          else begin
            de = done_q.pop_front();
            check("rdata",   o_rdata, de.rdata);
            check("bus_err", {63'b0, o_bus_err}, {63'b0, de.err});
          end
        end
      end
      prev_req = o_ext_req;
    end
  end

  // Drive one aligned access; ack arrives ack_dly REQ cycles after req rises.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input int ack_dly,
                           input logic [63:0] bus_rd, input int exp_stall);
    int stall_n;
    bit done;
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; func3 = f3; addr_i = a; wdata_i = wd; ext_ack = 1'b0;
    #1;
    check("issue_stall", {63'b0, o_stall}, 64'd1);
    check("issue_misaligned", {63'b0, o_misaligned}, 64'd0);
    stall_n = 1;
    done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      ext_ack   = (k == ack_dly);
      ext_rdata = bus_rd;
      #1;
      if (o_stall) stall_n++;
      else done = 1'b1;
    end
    ext_ack = 1'b0;
    check("done_reached", {63'b0, done}, 64'd1);
    check("stall_cycles", 64'(stall_n), 64'(exp_stall));
    // Request still held through DONE: it must not be reissued.
    @(posedge clk);
    #1;
    check("no_reissue", {63'b0, o_ext_req}, 64'd0);
    check("bus_err_one_cycle", {63'b0, o_bus_err}, 64'd0);
    @(negedge clk);
    mem_req = 1'b0; mem_we = 1'b0;
  endtask

  // Misaligned/illegal access, with a stray ack that must be ignored in IDLE.
  task automatic do_misaligned(input logic we, input logic [2:0] f3, input logic [63:0] a,
                               input logic [63:0] wd, input logic [63:0] exp_rdata);
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; func3 = f3; addr_i = a; wdata_i = wd;
    ext_ack = 1'b1; ext_rdata = '1;
    #1;
    check("misaligned_flag", {63'b0, o_misaligned}, 64'd1);
    check("misaligned_stall", {63'b0, o_stall}, 64'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("misaligned_no_req", {63'b0, o_ext_req}, 64'd0);
    end
    check("idle_ack_ignored", o_rdata, exp_rdata);
    @(negedge clk);
    mem_req = 1'b0; mem_we = 1'b0; ext_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; func3 = '0;
    addr_i = '0; wdata_i = '0; ext_ack = 1'b0; ext_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ext_req",   {63'b0, o_ext_req}, 64'd0);
    check("rst_ext_we",    {63'b0, o_ext_we}, 64'd0);
    check("rst_ext_be",    {56'b0, o_ext_be}, 64'd0);
    check("rst_ext_addr",  o_ext_addr, 64'd0);
    check("rst_ext_wdata", o_ext_wdata, 64'd0);
    check("rst_rdata",     o_rdata, 64'd0);
    check("rst_bus_err",   {63'b0, o_bus_err}, 64'd0);
    check("rst_stall",     {63'b0, o_stall}, 64'd0);
    arst_n = 1'b1;

    // ld 0x1000, ack three cycles into the request
    expect_txn(64'h1000, 8'hFF, 1'b0, 64'h0, 64'h0123456789ABCDEF, 1'b0);
    do_access(1'b0, F3_D, 64'h1000, 64'h0, 2, 64'h0123456789ABCDEF, 4);
    // lb / lbu at 0x1003 with byte 3 = 0x80
    expect_txn(64'h1000, 8'h08, 1'b0, 64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0);
    do_access(1'b0, F3_B, 64'h1003, 64'h0, 0, 64'h1122334480AABBCC, 2);
    expect_txn(64'h1000, 8'h08, 1'b0, 64'h0, 64'h0000000000000080, 1'b0);
    do_access(1'b0, F3_BU, 64'h1003, 64'h0, 0, 64'h1122334480AABBCC, 2);
    // sh at 0x2006; store clears o_rdata
    expect_txn(64'h2000, 8'hC0, 1'b1, 64'hBEEF000000000000, 64'h0, 1'b0);
    do_access(1'b1, F3_H, 64'h2006, 64'h123456789ABCBEEF, 1, 64'hDEADBEEFDEADBEEF, 3);
    // misaligned and illegal accesses
    do_misaligned(1'b0, F3_W, 64'h3002, 64'h0, 64'h0);
    do_misaligned(1'b1, F3_BU, 64'h3000, 64'h55, 64'h0);
    do_misaligned(1'b1, F3_H, 64'h2001, 64'h55, 64'h0);
    // more loads
    expect_txn(64'h4000, 8'hC0, 1'b0, 64'h0, 64'hFFFFFFFFFFFF8001, 1'b0);
    do_access(1'b0, F3_H, 64'h4006, 64'h0, 1, 64'h8001000000000000, 3);
    expect_txn(64'h5000, 8'hF0, 1'b0, 64'h0, 64'h00000000F00DCAFE, 1'b0);
    do_access(1'b0, F3_WU, 64'h5004, 64'h0, 0, 64'hF00DCAFE12345678, 2);
    expect_txn(64'h3000, 8'hF0, 1'b0, 64'h0, 64'hFFFFFFFF80000000, 1'b0);
    do_access(1'b0, F3_W, 64'h3004, 64'h0, 3, 64'h8000000000000000, 5);
    expect_txn(64'h9000, 8'h0C, 1'b0, 64'h0, 64'h0000000000009ABC, 1'b0);
    do_access(1'b0, F3_HU, 64'h9002, 64'h0, 0, 64'h000000009ABC0000, 2);
    // more stores
    expect_txn(64'h6000, 8'hF0, 1'b1, 64'hAABBCCDD00000000, 64'h0, 1'b0);
    do_access(1'b1, F3_W, 64'h6004, 64'h11223344AABBCCDD, 0, 64'h0, 2);
    expect_txn(64'h7000, 8'h02, 1'b1, 64'hFFFFFFFFFFFF5A00, 64'h0, 1'b0);
    do_access(1'b1, F3_B, 64'h7001, 64'hFFFFFFFFFFFFFF5A, 1, 64'h0, 3);
    expect_txn(64'h8000, 8'hFF, 1'b1, 64'h0102030405060708, 64'h0, 1'b0);
    do_access(1'b1, F3_D, 64'h8000, 64'h0102030405060708, 0, 64'h0, 2);
    do_misaligned(1'b0, F3_D, 64'h8004, 64'h0, 64'h0);

    // reset during the 2nd REQ cycle, request held so reset must win
    begin
      iss_t ie;
      ie.addr = 64'hA000; ie.be = 8'hFF; ie.we = 1'b0; ie.wdata = 64'h0;
      iss_q.push_back(ie);
    end
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; func3 = F3_D; addr_i = 64'hA000; wdata_i = 64'h0;
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_req_ext_req", {63'b0, o_ext_req}, 64'd0);
    check("rst_mid_req_ext_addr", o_ext_addr, 64'd0);
    @(negedge clk);
    arst_n = 1'b1; mem_req = 1'b0;
    ext_ack = 1'b1; ext_rdata = 64'h5555555555555555;
    #1;
    check("rst_mid_req_idle", {63'b0, o_stall}, 64'd0);
    @(posedge clk);
    #1;
    check("late_ack_no_req", {63'b0, o_ext_req}, 64'd0);
    check("late_ack_rdata", o_rdata, 64'd0);
    @(negedge clk);
    ext_ack = 1'b0;

`ifdef DATA_MEM_CTRL_TIMEOUT_EN
    // Load something nonzero first so the timeout's rdata=0 is visible.
    expect_txn(64'hB008, 8'hFF, 1'b0, 64'h0, 64'h77, 1'b0);
    do_access(1'b0, F3_D, 64'hB008, 64'h0, 0, 64'h77, 2);
    expect_txn(64'hB000, 8'hFF, 1'b0, 64'h0, 64'h0, 1'b1);
    do_access(1'b0, F3_D, 64'hB000, 64'h0, 99, 64'h1234, 5);
`endif

    repeat (3) @(negedge clk);
    check("iss_queue_drained", 64'(iss_q.size()), 64'd0);
    check("done_queue_drained", 64'(done_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
